mem_io_bridge: RTL and testbench

MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

---
 rtl/mem_io_bridge_if.sv | 27 ++
 rtl/mem_io_bridge.sv | 130 +++++++++++++
 tb/tb_mem_io_bridge.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_bridge_if.sv
// CPU/RAM/output-stream signal bundle of the memory-mapped I/O bridge.
// The slave modport is the bridge's view; master is the surrounding system.
interface mem_io_bridge_if #(
    parameter int M = 16
);
    logic [M-1:0] memAddr;
    logic [M-1:0] memWrite;
    logic         memWE;
    logic [M-1:0] memRead;
    logic [M-1:0] ramAddr;
    logic [M-1:0] ramWData;
    logic         ramWE;
    logic [M-1:0] ramRData;
    logic [M-1:0] outData;
    logic         outValid;
    logic         outReady;

    modport slave (
        input  memAddr, memWrite, memWE, ramRData, outReady,
        output memRead, ramAddr, ramWData, ramWE, outData, outValid
    );

    modport master (
        output memAddr, memWrite, memWE, ramRData, outReady,
        input  memRead, ramAddr, ramWData, ramWE, outData, outValid
    );
endinterface

// File: rtl/mem_io_bridge.sv
// Address decoder splitting CPU accesses between RAM and a small I/O page
// holding an output FIFO, a status register and a free-running timer/compare.
module mem_io_bridge #(
    parameter int M = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_io_bridge_if.slave    bus
);
    localparam logic [7:0]   OFF_OUT  = 8'h00;
    localparam logic [7:0]   OFF_STAT = 8'h01;
    localparam logic [7:0]   OFF_TMR  = 8'h02;
    localparam logic [7:0]   OFF_CMP  = 8'h03;
    localparam logic [M-1:0] ONE      = {{(M-1){1'b0}}, 1'b1};

    logic [M-1:0] r_fifo [4];
    logic [1:0]   r_rd;
    logic [1:0]   r_wr;
    logic [2:0]   r_count;
    logic         r_ovf;
    logic         r_tmr_flag;
    logic [M-1:0] r_timer;
    logic [M-1:0] r_compare;

    logic         w_io;
    logic [7:0]   w_off;
    logic         w_wr_out;
    logic         w_wr_stat;
    logic         w_wr_tmr;
    logic         w_wr_cmp;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_push;
    logic         w_ovf_set;
    logic         w_match;
    logic         w_tmr_set;
    logic [M-1:0] w_status;
    logic [M-1:0] w_mem_read;

    // The top 256 addresses form the I/O page; the low byte selects the register.
    assign w_io      = &bus.memAddr[M-1:8];
    assign w_off     = bus.memAddr[7:0];
    assign w_wr_out  = bus.memWE & w_io & (w_off == OFF_OUT);
    assign w_wr_stat = bus.memWE & w_io & (w_off == OFF_STAT);
    assign w_wr_tmr  = bus.memWE & w_io & (w_off == OFF_TMR);
    assign w_wr_cmp  = bus.memWE & w_io & (w_off == OFF_CMP);

    assign w_full    = (r_count == 3'd4);
    assign w_empty   = (r_count == 3'd0);
    assign w_pop     = ~w_empty & bus.outReady;
    assign w_push    = w_wr_out & (~w_full | w_pop);
    assign w_ovf_set = w_wr_out & w_full & ~w_pop;
    assign w_match   = (r_timer == r_compare);
    assign w_tmr_set = w_match & ~w_wr_tmr;
    assign w_status  = {{(M-4){1'b0}}, r_tmr_flag, r_ovf, w_full, w_empty};

    // Read-data mux: RAM passthrough or I/O register select.
    always_comb begin
        w_mem_read = {M{1'b0}};
        if (w_io) begin
            case (w_off)
                OFF_STAT: w_mem_read = w_status;
                OFF_TMR:  w_mem_read = r_timer;
                OFF_CMP:  w_mem_read = r_compare;
                default:  w_mem_read = {M{1'b0}};
            endcase
        end else begin
            w_mem_read = bus.ramRData;
        end
    end

    assign bus.memRead  = w_mem_read;
    assign bus.ramAddr  = bus.memAddr;
    assign bus.ramWData = bus.memWrite;
    assign bus.ramWE    = bus.memWE & ~w_io;
    assign bus.outData  = r_fifo[r_rd];
    assign bus.outValid = ~w_empty;

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= {M{1'b0}};
            end
            r_rd    <= 2'd0;
            r_wr    <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr] <= bus.memWrite;
                r_wr         <= r_wr + 2'd1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 2'd1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    // Sticky flags: a set event in the same cycle as its W1C clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf      <= 1'b0;
            r_tmr_flag <= 1'b0;
        end else begin
            r_ovf      <= w_ovf_set | (r_ovf & ~(w_wr_stat & bus.memWrite[2]));
            r_tmr_flag <= w_tmr_set | (r_tmr_flag & ~(w_wr_stat & bus.memWrite[3]));
        end
    end

    // Timer: CPU write beats compare match, which beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer   <= {M{1'b0}};
            r_compare <= {M{1'b1}};
        end else begin
            if (w_wr_tmr) begin
                r_timer <= bus.memWrite;
            end else if (w_match) begin
                r_timer <= {M{1'b0}};
            end else begin
                r_timer <= r_timer + ONE;
            end
            if (w_wr_cmp) begin
                r_compare <= bus.memWrite;
            end
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: decode table, directed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_mem_io_bridge;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    mem_io_bridge_if #(.M(16)) bus ();
    mem_io_bridge #(.M(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic [15:0] rdata;
        logic [15:0] exp_read;
        logic        exp_we;
    } vec_t;

    vec_t tbl[8];

    logic [15:0] mq[$];
    logic [15:0] m_timer;
    logic [15:0] m_cmp;
    bit          m_ovf;
    bit          m_flag;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic we, input logic rdy);
        bus.memAddr  = a;
        bus.memWrite = d;
        bus.memWE    = we;
        bus.outReady = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a, input logic [15:0] rd);
        if (a < 16'hFF00) return rd;
        case (a)
            16'hFF01: return {12'h000, m_flag, m_ovf, mq.size() == 4, mq.size() == 0};
            16'hFF02: return m_timer;
            16'hFF03: return m_cmp;
            default:  return 16'h0000;
        endcase
    endfunction

    initial begin
        bus.ramRData = 16'h0000;
        do_reset();

        // Reset state
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0); #1;
        chk("rst_status", bus.memRead, 16'h0001);
        chk("rst_valid", {15'h0, bus.outValid}, 16'h0000);
        chk("rst_outdata", bus.outData, 16'h0000);
        drive(16'hFF03, 16'h0000, 1'b0, 1'b0); #1;
        chk("rst_compare", bus.memRead, 16'hFFFF);

        // Decode table
        tbl[0] = '{16'h0010, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b1};
        tbl[1] = '{16'h0010, 16'h0000, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0};
        tbl[2] = '{16'hFEFF, 16'h5555, 1'b1, 16'h1111, 16'h1111, 1'b1};
        tbl[3] = '{16'hFF04, 16'h9999, 1'b1, 16'h2222, 16'h0000, 1'b0};
        tbl[4] = '{16'hFFFF, 16'h0000, 1'b0, 16'h3333, 16'h0000, 1'b0};
        tbl[5] = '{16'hFF00, 16'h0000, 1'b0, 16'h4444, 16'h0000, 1'b0};
        tbl[6] = '{16'h0000, 16'h0001, 1'b1, 16'h7777, 16'h7777, 1'b1};
        tbl[7] = '{16'hFF80, 16'hABCD, 1'b1, 16'h6666, 16'h0000, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].addr, tbl[i].wdata, tbl[i].we, 1'b0);
            bus.ramRData = tbl[i].rdata;
            #1;
            chk("tbl_read", bus.memRead, tbl[i].exp_read);
            chk("tbl_ramwe", {15'h0, bus.ramWE}, {15'h0, tbl[i].exp_we});
            chk("tbl_ramaddr", bus.ramAddr, tbl[i].addr);
            chk("tbl_ramwdata", bus.ramWData, tbl[i].wdata);
            tick();
        end

        // Fill past full with no consumer, then drain
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(16'hFF00, 16'h00A1 + 16'(i), 1'b1, 1'b0);
            tick();
        end
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0); #1;
        chk("full_status", bus.memRead, 16'h0006);
        drive(16'hFF01, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", {15'h0, bus.outValid}, 16'h0001);
            chk("drain_data", bus.outData, 16'h00A1 + 16'(i));
            tick();
        end
        #1;
        chk("drained_status", bus.memRead, 16'h0005);
        chk("drained_valid", {15'h0, bus.outValid}, 16'h0000);

        // Push into a full FIFO in the same cycle as a pop
        drive(16'hFF01, 16'h0004, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(16'hFF00, 16'h00C1 + 16'(i), 1'b1, 1'b0);
            tick();
        end
        drive(16'hFF00, 16'h00B0, 1'b1, 1'b1); #1;
        chk("pp_head", bus.outData, 16'h00C1);
        tick();
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0); #1;
        chk("pp_status", bus.memRead, 16'h0002);
        drive(16'hFF01, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("pp_data", bus.outData, (i == 3) ? 16'h00B0 : 16'h00C2 + 16'(i));
            tick();
        end
        #1;
        chk("pp_end_status", bus.memRead, 16'h0001);

        // Timer compare wrap, flag clear, set-wins-over-clear
        drive(16'hFF03, 16'h0003, 1'b1, 1'b0); tick();
        drive(16'hFF02, 16'h0000, 1'b1, 1'b0); tick();
        drive(16'hFF02, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("tmr_seq", bus.memRead, 16'((i == 4) ? 0 : i));
            tick();
        end
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0); #1;
        chk("tmr_flag_set", bus.memRead, 16'h0009);
        drive(16'hFF01, 16'h0008, 1'b1, 1'b0); tick();
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0); #1;
        chk("tmr_flag_clr", bus.memRead, 16'h0001);
        tick();
        drive(16'hFF01, 16'h0008, 1'b1, 1'b0); tick();
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0); #1;
        chk("tmr_set_wins", bus.memRead, 16'h0009);

        // Reset asserted mid-operation
        do_reset();
        drive(16'hFF00, 16'h00D1, 1'b1, 1'b0); tick();
        drive(16'hFF00, 16'h00D2, 1'b1, 1'b0); tick();
        drive(16'hFF02, 16'h0040, 1'b1, 1'b0); tick();
        drive(16'hFF02, 16'h0000, 1'b0, 1'b0); #1;
        chk("pre_rst_timer", bus.memRead, 16'h0040);
        chk("pre_rst_valid", {15'h0, bus.outValid}, 16'h0001);
        rst = 1'b1; #1;
        chk("mid_rst_valid", {15'h0, bus.outValid}, 16'h0000);
        chk("mid_rst_outdata", bus.outData, 16'h0000);
        chk("mid_rst_timer", bus.memRead, 16'h0000);
        drive(16'hFF01, 16'h0000, 1'b0, 1'b0); #1;
        chk("mid_rst_status", bus.memRead, 16'h0001);
        drive(16'hFF03, 16'h0000, 1'b0, 1'b0); #1;
        chk("mid_rst_compare", bus.memRead, 16'hFFFF);
        tick();
        rst = 1'b0;

        // Randomized traffic against the reference model
        do_reset();
        mq.delete();
        m_timer = 16'h0000;
        m_cmp   = 16'hFFFF;
        m_ovf   = 1'b0;
        m_flag  = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [15:0] a, d, rd;
            logic        we, rdy, pop, push, ovf_set, fset;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel < 3)       a = 16'($urandom_range(0, 16'hFEFF));
            else if (sel < 9)  a = 16'hFF00 + 16'(sel - 3);
            else               a = 16'hFFFF;
            d   = 16'($urandom);
            if (a == 16'hFF02 || a == 16'hFF03) d = 16'($urandom_range(0, 12));
            we  = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 3) == 0);
            rd  = 16'($urandom);
            drive(a, d, we, rdy);
            bus.ramRData = rd;
            #1;
            chk("rnd_read", bus.memRead, model_read(a, rd));
            chk("rnd_ramwe", {15'h0, bus.ramWE}, {15'h0, we && (a < 16'hFF00)});
            chk("rnd_valid", {15'h0, bus.outValid}, {15'h0, mq.size() != 0});
            if (mq.size() != 0) chk("rnd_outdata", bus.outData, mq[0]);

            pop     = (mq.size() != 0) && rdy;
            push    = we && (a == 16'hFF00);
            ovf_set = push && (mq.size() == 4) && !pop;
            fset    = 1'b0;
            if (pop) void'(mq.pop_front());
            if (push && mq.size() < 4) mq.push_back(d);
            if (we && a == 16'hFF02) m_timer = d;
            else if (m_timer == m_cmp) begin
                m_timer = 16'h0000;
                fset    = 1'b1;
            end else m_timer = m_timer + 16'h0001;
            if (we && a == 16'hFF03) m_cmp = d;
            if (we && a == 16'hFF01) begin
                if (d[2]) m_ovf = 1'b0;
                if (d[3]) m_flag = 1'b0;
            end
            m_ovf  = m_ovf | ovf_set;
            m_flag = m_flag | fset;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
